// File: rtl/mem_write_checker.sv
// Store-stream checker: matches core data-memory writes against a table of expected
// (address, data) pairs. Define MWCHK_ORDERED_EN to require stores in table order.
module mem_write_checker #(
    parameter  int XLEN    = 32,
    parameter  int NUM_EXP = 4,
    parameter  int TIMEOUT = 1000,
    localparam int CNT_W   = $clog2(TIMEOUT + 1),
    localparam int MC_W    = $clog2(NUM_EXP + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mem_write,
    input  logic [XLEN-1:0]         data_adr,
    input  logic [XLEN-1:0]         write_data,
    input  logic [NUM_EXP*XLEN-1:0] exp_adr,
    input  logic [NUM_EXP*XLEN-1:0] exp_data,
    input  logic                    ign_en,
    input  logic [XLEN-1:0]         ign_adr,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [MC_W-1:0]         match_cnt,
    output logic [XLEN-1:0]         fail_adr,
    output logic [XLEN-1:0]         fail_data,
    output logic [CNT_W-1:0]        cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [MC_W-1:0]  LAST_IDX = MC_W'(NUM_EXP - 1);

    state_e                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
    logic                      fail_q, fail_d;
    logic                      timeout_q, timeout_d;
    logic [MC_W-1:0]           match_cnt_q, match_cnt_d;
    logic [XLEN-1:0]           fail_adr_q, fail_adr_d;
    logic [XLEN-1:0]           fail_data_q, fail_data_d;
    logic [CNT_W-1:0]          cycle_cnt_q, cycle_cnt_d;
    logic [NUM_EXP-1:0]        hit_q, hit_d;
    logic [NUM_EXP*XLEN-1:0]   exp_adr_q, exp_adr_d;
    logic [NUM_EXP*XLEN-1:0]   exp_data_q, exp_data_d;
    logic                      ign_en_q, ign_en_d;
    logic [XLEN-1:0]           ign_adr_q, ign_adr_d;

    logic [NUM_EXP-1:0]        entry_match_s;
    logic [NUM_EXP-1:0]        eligible_s;
    logic [NUM_EXP-1:0]        hit_sel_s;
    logic                      hit_found_s;
    logic                      ignore_s;
    logic [CNT_W-1:0]          cnt_inc_s;
    logic                      tmo_reach_s;

    // Per-entry compare and eligibility; lowest eligible matching index is selected.
    always_comb begin
        entry_match_s = '0;
        eligible_s    = '0;
        hit_sel_s     = '0;
        hit_found_s   = 1'b0;
        for (int i = 0; i < NUM_EXP; i++) begin
            entry_match_s[i] = (data_adr == exp_adr_q[i*XLEN +: XLEN]) &&
                               (write_data == exp_data_q[i*XLEN +: XLEN]);
`ifdef MWCHK_ORDERED_EN
            eligible_s[i] = !hit_q[i] && (match_cnt_q == MC_W'(i));
`else
            eligible_s[i] = !hit_q[i];
`endif
            if (!hit_found_s && entry_match_s[i] && eligible_s[i]) begin
                hit_sel_s[i] = 1'b1;
                hit_found_s  = 1'b1;
            end else begin
                hit_sel_s[i] = 1'b0;
            end
        end
    end

    // Ignore filter and saturating cycle counter increment.
    always_comb begin
        ignore_s = ign_en_q && (data_adr == ign_adr_q);
        if (cycle_cnt_q == CNT_MAX) begin
            cnt_inc_s = cycle_cnt_q;
        end else begin
            cnt_inc_s = cycle_cnt_q + CNT_W'(1);
        end
        tmo_reach_s = (cnt_inc_s >= TMO_VAL);
    end

    // Next-state, counters, captured tables and registered verdict outputs.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        cycle_cnt_d = cycle_cnt_q;
        hit_d       = hit_q;
        exp_adr_d   = exp_adr_q;
        exp_data_d  = exp_data_q;
        ign_en_d    = ign_en_q;
        ign_adr_d   = ign_adr_q;

        if (start) begin
            // A store in the arming cycle is deliberately not evaluated.
            state_d     = S_RUN;
            exp_adr_d   = exp_adr;
            exp_data_d  = exp_data;
            ign_en_d    = ign_en;
            ign_adr_d   = ign_adr;
            hit_d       = '0;
            match_cnt_d = '0;
            cycle_cnt_d = '0;
            fail_adr_d  = '0;
            fail_data_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cycle_cnt_d = cnt_inc_s;
                    if (mem_write && !ignore_s) begin
                        if (hit_found_s) begin
                            hit_d       = hit_q | hit_sel_s;
                            match_cnt_d = match_cnt_q + MC_W'(1);
                            if (match_cnt_q == LAST_IDX) begin
                                state_d = S_PASS;
                            end else if (tmo_reach_s) begin
                                state_d = S_TMO;
                            end else begin
                                state_d = S_RUN;
                            end
                        end else begin
                            state_d     = S_FAIL;
                            fail_adr_d  = data_adr;
                            fail_data_d = write_data;
                        end
                    end else if (tmo_reach_s) begin
                        state_d = S_TMO;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_IDLE, S_PASS, S_FAIL, S_TMO: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d    = (state_d == S_RUN);
        pass_d    = (state_d == S_PASS);
        fail_d    = (state_d == S_FAIL);
        timeout_d = (state_d == S_TMO);
        done_d    = pass_d || fail_d || timeout_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            match_cnt_q <= '0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
            cycle_cnt_q <= '0;
            hit_q       <= '0;
            exp_adr_q   <= '0;
            exp_data_q  <= '0;
            ign_en_q    <= 1'b0;
            ign_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            match_cnt_q <= match_cnt_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            cycle_cnt_q <= cycle_cnt_d;
            hit_q       <= hit_d;
            exp_adr_q   <= exp_adr_d;
            exp_data_q  <= exp_data_d;
            ign_en_q    <= ign_en_d;
            ign_adr_q   <= ign_adr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign match_cnt = match_cnt_q;
    assign fail_adr  = fail_adr_q;
    assign fail_data = fail_data_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a vector table plus hand-written timeout/priority sequences,
// checked through an expected-result queue.
module tb_mem_write_checker;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [1:0]  mc;
        logic [31:0] fadr;
        logic [31:0] fdat;
        logic [4:0]  cyc;
    } exp_t;

    typedef struct packed {
        logic        rst_n;
        logic        start;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        ign_en = 1'b0;
    logic [31:0] ign_adr = 32'd0;

    logic [63:0] exp_adr2  = {32'h14, 32'h10};
    logic [63:0] exp_data2 = {32'd2, 32'd1};
    logic [31:0] exp_adr1  = 32'd100;
    logic [31:0] exp_data1 = 32'd25;

    logic        busy2, done2, pass2, fail2, tmo2;
    logic [1:0]  mc2;
    logic [31:0] fadr2, fdat2;
    logic [4:0]  cyc2;
    logic        busy1, done1, pass1, fail1, tmo1;
    logic [0:0]  mc1;
    logic [31:0] fadr1, fdat1;
    logic [4:0]  cyc1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t vecs[17];

    always #5 clk = ~clk;

    mem_write_checker #(.XLEN(32), .NUM_EXP(2), .TIMEOUT(20)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data),
        .exp_adr(exp_adr2), .exp_data(exp_data2),
        .ign_en(ign_en), .ign_adr(ign_adr),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .timeout(tmo2),
        .match_cnt(mc2), .fail_adr(fadr2), .fail_data(fdat2), .cycle_cnt(cyc2)
    );

    mem_write_checker #(.XLEN(32), .NUM_EXP(1), .TIMEOUT(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data),
        .exp_adr(exp_adr1), .exp_data(exp_data1),
        .ign_en(ign_en), .ign_adr(ign_adr),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timeout(tmo1),
        .match_cnt(mc1), .fail_adr(fadr1), .fail_data(fdat1), .cycle_cnt(cyc1)
    );

    function automatic exp_t mk(input logic b, input logic d, input logic p, input logic f,
                                input logic t, input logic [1:0] mc, input logic [31:0] fa,
                                input logic [31:0] fd, input logic [4:0] cy);
        exp_t e;
        e.busy = b; e.done = d; e.pass = p; e.fail = f; e.tmo = t;
        e.mc = mc; e.fadr = fa; e.fdat = fd; e.cyc = cy;
        return e;
    endfunction

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input string name, input logic r, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input exp_t e,
                        input bit use1);
        exp_t got;
        exp_t want;
        rst_n = r; start = s; mem_write = w; data_adr = a; write_data = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (use1) begin
            got = mk(busy1, done1, pass1, fail1, tmo1, {1'b0, mc1}, fadr1, fdat1, cyc1);
        end else begin
            got = mk(busy2, done2, pass2, fail2, tmo2, mc2, fadr2, fdat2, cyc2);
        end
        want = sb.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got b%0b d%0b p%0b f%0b t%0b mc=%0d fadr=%0h fdat=%0h cyc=%0d, want b%0b d%0b p%0b f%0b t%0b mc=%0d fadr=%0h fdat=%0h cyc=%0d",
                     name, got.busy, got.done, got.pass, got.fail, got.tmo, got.mc, got.fadr,
                     got.fdat, got.cyc, want.busy, want.done, want.pass, want.fail, want.tmo,
                     want.mc, want.fadr, want.fdat, want.cyc);
        end
    endtask

    initial begin
        exp_t z, run0, ord_fail;
        z        = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        run0     = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        ord_fail = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h14, 32'd2, 5'd1);

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'd0,  z};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,  z};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h14, 32'd2,  run0};
`ifdef MWCHK_ORDERED_EN
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h14, 32'd2,  ord_fail};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h20, 32'd99, ord_fail};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,  ord_fail};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'd0,  ord_fail};
`else
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h14, 32'd2,
                     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd1)};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h20, 32'd99,
                     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd2)};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
                     mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0, 5'd3)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'd0,
                     mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0, 5'd3)};
`endif
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'd0,  run0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
                     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd1)};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
                     mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h10, 32'd1, 5'd2)};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'd0,  run0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
                     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd1)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'd0,  z};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'd0,  run0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
                     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd1)};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'd0,
                     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd2)};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h14, 32'd2,
                     mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0, 5'd3)};

        ign_en  = 1'b1;
        ign_adr = 32'h20;
        for (int i = 0; i < 17; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].start, vecs[i].we,
                 vecs[i].adr, vecs[i].dat, vecs[i].e, 1'b0);
        end

        // Timeout with a store that matches an entry but is ignored (ignore wins).
        ign_adr = 32'h10;
        step("tmo_start", 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, run0, 1'b0);
        step("tmo_ign", 1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd1), 1'b0);
        for (int k = 2; k < 20; k++) begin
            step("tmo_run", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
                 mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'(k)), 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step("tmo_hold", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
                 mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 5'd20), 1'b0);
        end

        // Final hit on the timeout edge takes priority: PASS.
        ign_adr = 32'h20;
        step("ph_start", 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, run0, 1'b0);
        step("ph_hit0", 1'b1, 1'b0, 1'b1, 32'h10, 32'd1,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd1), 1'b0);
        for (int k = 2; k < 20; k++) begin
            step("ph_run", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
                 mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'(k)), 1'b0);
        end
        step("ph_last", 1'b1, 1'b0, 1'b1, 32'h14, 32'd2,
             mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0, 5'd20), 1'b0);

        // Bad store on the timeout edge takes priority: FAIL.
        step("pf_start", 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, run0, 1'b0);
        for (int k = 1; k < 20; k++) begin
            step("pf_run", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
                 mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'(k)), 1'b0);
        end
        step("pf_bad", 1'b1, 1'b0, 1'b1, 32'h30, 32'd5,
             mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h30, 32'd5, 5'd20), 1'b0);

        // Single-entry table: scratch store then the expected one.
        ign_adr = 32'd96;
        step("t1_start", 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, run0, 1'b1);
        step("t1_c1", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd1), 1'b1);
        step("t1_c2", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd2), 1'b1);
        step("t1_scratch", 1'b1, 1'b0, 1'b1, 32'd96, 32'd7,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd3), 1'b1);
        step("t1_c4", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd4), 1'b1);
        step("t1_pass", 1'b1, 1'b0, 1'b1, 32'd100, 32'd25,
             mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd5), 1'b1);

        // Wrong data on the expected address.
        step("t2_start", 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, run0, 1'b1);
        step("t2_fail", 1'b1, 1'b0, 1'b1, 32'd100, 32'd24,
             mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd100, 32'd24, 5'd1), 1'b1);

        // Ignored address equal to the only entry, then re-arm mid-run.
        ign_adr = 32'd100;
        step("ig_start", 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, run0, 1'b1);
        step("ig_store", 1'b1, 1'b0, 1'b1, 32'd100, 32'd25,
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd1), 1'b1);
        ign_adr = 32'd96;
        step("ig_rearm", 1'b1, 1'b1, 1'b1, 32'd100, 32'd25, run0, 1'b1);
        step("ig_pass", 1'b1, 1'b0, 1'b1, 32'd100, 32'd25,
             mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 5'd1), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
